// File: rtl/dot_matvec_seq_pkg.sv
// rtl/dot_matvec_seq_pkg.sv - shared FSM encoding, default sizes and result width helper
package dot_matvec_seq_pkg;

  localparam int N_DEF     = 8;
  localparam int N_BIT_DEF = 3;
  localparam int DW_DEF    = 8;
  localparam int M_BIT_DEF = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_VEC = 3'd1,
    RUN      = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  function automatic int res_width(input int dw, input int n_bit);
    return 2 * dw + n_bit;
  endfunction

endpackage

// File: rtl/dot_matvec_seq_dot_product.sv
// rtl/dot_matvec_seq_dot_product.sv - combinational N-lane unsigned dot product
module dot_product
  import dot_matvec_seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int N_BIT = N_BIT_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic [DW*N-1:0]                    inp1,
  input  logic [DW*N-1:0]                    inp2,
  output logic [res_width(DW, N_BIT)-1:0]    outp
);

  localparam int RW = res_width(DW, N_BIT);

  logic [2*DW-1:0] prod;

  always_comb begin
    outp = '0;
    prod = '0;
    for (int i = 0; i < N; i++) begin
      prod = {{DW{1'b0}}, inp1[i*DW +: DW]} * {{DW{1'b0}}, inp2[i*DW +: DW]};
      outp = outp + RW'(prod);
    end
  end

endmodule

// File: rtl/dot_matvec_seq.sv
// rtl/dot_matvec_seq.sv - row-at-a-time matrix-vector sequencer around one dot_product
// Optional DOT_MATVEC_ROW_TAG_EN adds res_tag, the zero-based row index of res_data.
module dot_matvec_seq
  import dot_matvec_seq_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int N_BIT = N_BIT_DEF,
  parameter int DW    = DW_DEF,
  parameter int M_BIT = M_BIT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [M_BIT-1:0]                  num_rows,
  input  logic                              vec_valid,
  output logic                              vec_ready,
  input  logic [DW*N-1:0]                   vec_data,
  input  logic                              row_valid,
  output logic                              row_ready,
  input  logic [DW*N-1:0]                   row_data,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [res_width(DW, N_BIT)-1:0]   res_data,
  output logic                              busy,
`ifdef DOT_MATVEC_ROW_TAG_EN
  output logic [M_BIT-1:0]                  res_tag,
`endif
  output logic                              done
);

  localparam int RW = res_width(DW, N_BIT);

  state_t           state, state_nxt;
  logic [M_BIT-1:0] rows_total;
  logic [M_BIT-1:0] rows_acc;
  logic [DW*N-1:0]  vec_reg;
  logic [RW-1:0]    dot_out;
  logic             row_accept;

  dot_product #(.N(N), .N_BIT(N_BIT), .DW(DW)) u_dot (
    .inp1 (vec_reg),
    .inp2 (row_data),
    .outp (dot_out)
  );

  assign row_accept = row_valid && row_ready;

  always_comb begin
    state_nxt = state;
    vec_ready = 1'b0;
    row_ready = 1'b0;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_nxt = (num_rows == '0) ? DONE : LOAD_VEC;
      end
      LOAD_VEC: begin
        vec_ready = 1'b1;
        if (vec_valid) state_nxt = RUN;
      end
      RUN: begin
        // a row may enter only when the output register is free or draining this cycle
        row_ready = (!res_valid || res_ready) && (rows_acc < rows_total);
        if (row_accept && ((rows_acc + M_BIT'(1)) == rows_total)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (res_valid && res_ready) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rows_total <= '0;
      rows_acc   <= '0;
      vec_reg    <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
`ifdef DOT_MATVEC_ROW_TAG_EN
      res_tag    <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        rows_total <= num_rows;
        rows_acc   <= '0;
      end
      if (state == LOAD_VEC && vec_valid) vec_reg <= vec_data;
      if (row_accept) begin
        res_data  <= dot_out;
        res_valid <= 1'b1;
        rows_acc  <= rows_acc + M_BIT'(1);
`ifdef DOT_MATVEC_ROW_TAG_EN
        res_tag   <= rows_acc;
`endif
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dot_matvec_seq.sv
// tb/tb_dot_matvec_seq.sv - directed self-checking bench for dot_matvec_seq
module tb_dot_matvec_seq;

  localparam int N = 8, N_BIT = 3, DW = 8, M_BIT = 8;
  localparam int RW = 2 * DW + N_BIT;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [M_BIT-1:0]  num_rows;
  logic              vec_valid;
  logic              vec_ready;
  logic [DW*N-1:0]   vec_data;
  logic              row_valid;
  logic              row_ready;
  logic [DW*N-1:0]   row_data;
  logic              res_valid;
  logic              res_ready;
  logic [RW-1:0]     res_data;
  logic              busy;
  logic              done;
`ifdef DOT_MATVEC_ROW_TAG_EN
  logic [M_BIT-1:0]  res_tag;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dot_matvec_seq #(.N(N), .N_BIT(N_BIT), .DW(DW), .M_BIT(M_BIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_rows  (num_rows),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
`ifdef DOT_MATVEC_ROW_TAG_EN
    .res_tag   (res_tag),
`endif
    .done      (done)
  );

  function automatic logic [DW*N-1:0] fill(input logic [DW-1:0] b);
    logic [DW*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = b;
    return v;
  endfunction

  function automatic logic [DW*N-1:0] ramp();
    logic [DW*N-1:0] v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(i);
    return v;
  endfunction

  task automatic start_job(input logic [M_BIT-1:0] nr, input logic [DW*N-1:0] v);
    @(negedge clk); start = 1'b1; num_rows = nr;
    @(negedge clk); start = 1'b0; vec_valid = 1'b1; vec_data = v;
    @(negedge clk); vec_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_rows = '0; vec_valid = 1'b0; vec_data = '0;
    row_valid = 1'b0; row_data = '0; res_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || res_data !== '0 ||
        vec_ready !== 1'b0 || row_ready !== 1'b0)
      $display("FAIL reset_state got busy=%b rv=%b done=%b rd=%0d vr=%b rr=%b required all 0",
               busy, res_valid, done, res_data, vec_ready, row_ready);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk); start = 1'b1; num_rows = 8'd3;
    @(negedge clk); start = 1'b0; vec_valid = 1'b1; vec_data = fill(8'd1);
    #1;
    total_cnt++;
    if (vec_ready !== 1'b1 || busy !== 1'b1)
      $display("FAIL basic_load got vec_ready=%b busy=%b required 1 1", vec_ready, busy);
    else pass_cnt++;
    @(negedge clk); vec_valid = 1'b0; row_valid = 1'b1; row_data = fill(8'd1); res_ready = 1'b1;
    #1;
    total_cnt++;
    if (row_ready !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL basic_first_ready got rr=%b rv=%b required 1 0", row_ready, res_valid);
    else pass_cnt++;
    @(negedge clk); row_data = fill(8'd2);
    #1;
    total_cnt++;
    if (res_valid !== 1'b1 || res_data !== 19'd8 || row_ready !== 1'b1)
      $display("FAIL basic_row0 got rv=%b data=%0d rr=%b required 1 8 1", res_valid, res_data, row_ready);
    else pass_cnt++;
    @(negedge clk); row_data = ramp();
    #1;
    total_cnt++;
    if (res_data !== 19'd16 || row_ready !== 1'b1)
      $display("FAIL basic_row1 got data=%0d rr=%b required 16 1", res_data, row_ready);
    else pass_cnt++;
    @(negedge clk); row_valid = 1'b0;
    #1;
    total_cnt++;
    if (res_data !== 19'd28 || row_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL basic_row2 got data=%0d rr=%b done=%b required 28 0 0", res_data, row_ready, done);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b1 || res_valid !== 1'b0)
      $display("FAIL basic_done got done=%b rv=%b required 1 0", done, res_valid);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_idle got done=%b busy=%b required 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad;
    start_job(8'd3, fill(8'd1));
    row_valid = 1'b1; row_data = fill(8'd3); res_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); row_data = fill(8'd4);
      #1;
      if (row_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== 19'd24) bad++;
    end
    total_cnt++;
    if (bad != 0)
      $display("FAIL bp_hold got %0d bad cycles (last rr=%b rv=%b data=%0d) required 0", bad, row_ready, res_valid, res_data);
    else pass_cnt++;
    @(negedge clk); res_ready = 1'b1;
    #1;
    total_cnt++;
    if (row_ready !== 1'b1)
      $display("FAIL bp_release_ready got rr=%b required 1", row_ready);
    else pass_cnt++;
    @(negedge clk); row_data = fill(8'd5);
    #1;
    total_cnt++;
    if (res_valid !== 1'b1 || res_data !== 19'd32)
      $display("FAIL bp_row1 got rv=%b data=%0d required 1 32", res_valid, res_data);
    else pass_cnt++;
    @(negedge clk); row_valid = 1'b0;
    #1;
    total_cnt++;
    if (res_data !== 19'd40)
      $display("FAIL bp_row2 got data=%0d required 40", res_data);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b1)
      $display("FAIL bp_done got done=%b required 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_max_values();
    start_job(8'd1, fill(8'd255));
    row_valid = 1'b1; row_data = fill(8'd255); res_ready = 1'b1;
    @(negedge clk); row_valid = 1'b0;
    #1;
    total_cnt++;
    if (res_valid !== 1'b1 || res_data !== 19'd520200)
      $display("FAIL max_data got rv=%b data=%0d required 1 520200", res_valid, res_data);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b1)
      $display("FAIL max_done got done=%b required 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_zero_rows();
    int ready_seen;
    ready_seen = 0;
    @(negedge clk); start = 1'b1; num_rows = 8'd0; vec_valid = 1'b1; row_valid = 1'b1;
    #1;
    if (vec_ready !== 1'b0 || row_ready !== 1'b0) ready_seen++;
    @(negedge clk); start = 1'b0;
    #1;
    if (vec_ready !== 1'b0 || row_ready !== 1'b0) ready_seen++;
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b1)
      $display("FAIL zero_done got done=%b busy=%b required 1 1", done, busy);
    else pass_cnt++;
    @(negedge clk);
    #1;
    if (vec_ready !== 1'b0 || row_ready !== 1'b0) ready_seen++;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_idle got done=%b busy=%b required 0 0", done, busy);
    else pass_cnt++;
    total_cnt++;
    if (ready_seen != 0)
      $display("FAIL zero_no_ready got %0d cycles with a ready high required 0", ready_seen);
    else pass_cnt++;
    vec_valid = 1'b0; row_valid = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    start_job(8'd4, fill(8'd1));
    row_valid = 1'b1; row_data = fill(8'd1); res_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0; row_valid = 1'b0;
    @(negedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || res_data !== '0)
      $display("FAIL midrst_state got busy=%b rv=%b done=%b data=%0d required 0 0 0 0", busy, res_valid, done, res_data);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL midrst_quiet got done=%b busy=%b required 0 0", done, busy);
    else pass_cnt++;
    start_job(8'd2, ramp());
    row_valid = 1'b1; row_data = fill(8'd1);
    @(negedge clk); row_data = fill(8'd2);
    #1;
    total_cnt++;
    if (res_valid !== 1'b1 || res_data !== 19'd28)
      $display("FAIL midrst_new_row0 got rv=%b data=%0d required 1 28", res_valid, res_data);
    else pass_cnt++;
    @(negedge clk); row_valid = 1'b0;
    #1;
    total_cnt++;
    if (res_data !== 19'd56)
      $display("FAIL midrst_new_row1 got data=%0d required 56", res_data);
    else pass_cnt++;
    @(negedge clk); #1;
    total_cnt++;
    if (done !== 1'b1)
      $display("FAIL midrst_new_done got done=%b required 1", done);
    else pass_cnt++;
    @(negedge clk);
  endtask

`ifdef DOT_MATVEC_ROW_TAG_EN
  task automatic test_row_tag();
    int sent, got, bad, cyc;
    sent = 0; got = 0; bad = 0; cyc = 0;
    start_job(8'd4, fill(8'd1));
    while (got < 4 && cyc < 200) begin
      res_ready = 1'($urandom_range(0, 1));
      row_valid = (sent < 4);
      row_data  = fill(DW'(sent + 1));
      #1;
      if (res_valid && res_ready) begin
        if (res_tag !== M_BIT'(got) || res_data !== RW'(8 * (got + 1))) begin
          $display("FAIL tag_row%0d got tag=%0d data=%0d required %0d %0d", got, res_tag, res_data, got, 8 * (got + 1));
          bad++;
        end
        got++;
      end
      if (row_valid && row_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    total_cnt++;
    if (got != 4 || bad != 0)
      $display("FAIL tag_stream got %0d results %0d wrong required 4 0", got, bad);
    else pass_cnt++;
    row_valid = 1'b0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_max_values();
    test_zero_rows();
    test_reset_mid_job();
`ifdef DOT_MATVEC_ROW_TAG_EN
    test_row_tag();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
